lifo_arbiter: RTL and testbench

- Round-robin arbiter sharing one LIFO instance (sync srst, 1-cycle registered q_o, empty/full/usedw flags) between NUM_REQ requesters.
- Each requester issues push or pop transactions over a req/ack handshake; the arbiter drives the LIFO command port and routes pop data back to the owning requester.
- Keeps a shadow occupancy count so grant decisions never over-fill or under-read the LIFO. It also sequences LIFO reset at start-up and on flush.

---
 rtl/lifo_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_lifo_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ push/pop requesters onto one LIFO.
// Optional usedw consistency checker enabled by defining LIFO_ARB_CHECK_EN.
module lifo_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_pop_i,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DWIDTH-1:0]         rsp_data_o,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      err_o,
  output logic                      lifo_srst_o,
  output logic                      lifo_wrreq_o,
  output logic [DWIDTH-1:0]         lifo_data_o,
  output logic                      lifo_rdreq_o,
  input  logic [DWIDTH-1:0]         lifo_q_i,
  input  logic [AWIDTH:0]           lifo_usedw_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]         state_reg;
  logic               init_cnt_reg;
  logic [AWIDTH:0]    cnt_reg;
  logic [IW-1:0]      ptr_reg;
  logic               srst_reg;
  logic               wrreq_reg;
  logic               rdreq_reg;
  logic [DWIDTH-1:0]  wdata_reg;
  logic               tag1_vld_reg;
  logic [IW-1:0]      tag1_reg;
  logic               tag2_vld_reg;
  logic [IW-1:0]      tag2_reg;
  logic [NUM_REQ-1:0] rsp_vld_reg;
  logic [DWIDTH-1:0]  rsp_data_reg;

  logic               cnt_empty;
  logic               cnt_full;
  logic               pipe_empty;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] rsp_hit;
  logic [DWIDTH-1:0]  push_data [NUM_REQ];
  logic               grant_vld;
  logic [IW-1:0]      grant_idx;
  logic               grant_pop;

  assign cnt_empty  = (cnt_reg == '0);
  assign cnt_full   = (cnt_reg == DEPTH);
  assign pipe_empty = !tag1_vld_reg && !tag2_vld_reg;

  // Ineligible requesters are simply skipped by the search below.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign elig[gi]      = req_i[gi] & (req_pop_i[gi] ? !cnt_empty : !cnt_full);
    assign push_data[gi] = req_data_i[gi*DWIDTH +: DWIDTH];
    assign ack_o[gi]     = grant_vld && (grant_idx == IW'(gi));
    assign rsp_hit[gi]   = tag2_vld_reg && (tag2_reg == IW'(gi));
  end

  always_comb begin
    int      k;
    logic [IW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = 0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k    = (int'(ptr_reg) + i) % NUM_REQ;
      cand = IW'(k);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (state_reg != ST_RUN) grant_vld = 1'b0;
  end

  assign grant_pop = req_pop_i[grant_idx];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= 1'b0;
      srst_reg     <= 1'b1;
      cnt_reg      <= '0;
      ptr_reg      <= IW'(NUM_REQ - 1);
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (init_cnt_reg) begin
            state_reg <= ST_RUN;
            srst_reg  <= 1'b0;
          end else begin
            init_cnt_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush_i) state_reg <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Outstanding pops must read the LIFO before it is cleared.
          if (srst_reg) begin
            srst_reg  <= 1'b0;
            state_reg <= ST_RUN;
          end else if (pipe_empty) begin
            srst_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_INIT;
      endcase

      if (state_reg == ST_FLUSH && !srst_reg && pipe_empty) begin
        cnt_reg <= '0;
      end else if (grant_vld) begin
        cnt_reg <= grant_pop ? cnt_reg - 1'b1 : cnt_reg + 1'b1;
      end
      if (grant_vld) ptr_reg <= grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wrreq_reg    <= 1'b0;
      rdreq_reg    <= 1'b0;
      wdata_reg    <= '0;
      tag1_vld_reg <= 1'b0;
      tag1_reg     <= '0;
      tag2_vld_reg <= 1'b0;
      tag2_reg     <= '0;
      rsp_vld_reg  <= '0;
      rsp_data_reg <= '0;
    end else begin
      wrreq_reg <= grant_vld && !grant_pop;
      rdreq_reg <= grant_vld && grant_pop;
      if (grant_vld && !grant_pop) wdata_reg <= push_data[grant_idx];
      // Stage 1 covers the LIFO read, stage 2 the registered q_o capture.
      tag1_vld_reg <= grant_vld && grant_pop;
      tag1_reg     <= grant_idx;
      tag2_vld_reg <= tag1_vld_reg;
      tag2_reg     <= tag1_reg;
      rsp_vld_reg  <= rsp_hit;
      if (tag2_vld_reg) rsp_data_reg <= lifo_q_i;
    end
  end

`ifdef LIFO_ARB_CHECK_EN
  logic [AWIDTH:0] cnt_d_reg;
  logic            err_reg;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_d_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      cnt_d_reg <= cnt_reg;
      if (state_reg == ST_RUN && lifo_usedw_i != cnt_d_reg) err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  logic usedw_unused;
  assign usedw_unused = ^lifo_usedw_i;
  assign err_o        = 1'b0;
`endif

  assign busy_o       = (state_reg != ST_RUN);
  assign lifo_srst_o  = srst_reg;
  assign lifo_wrreq_o = wrreq_reg;
  assign lifo_rdreq_o = rdreq_reg;
  assign lifo_data_o  = wdata_reg;
  assign rsp_valid_o  = rsp_vld_reg;
  assign rsp_data_o   = rsp_data_reg;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Scoreboard bench for lifo_arbiter with a behavioural LIFO attached.
module tb_lifo_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_i = '0;
  logic [NR-1:0]   req_pop_i = '0;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR-1:0]   ack_o;
  logic [NR-1:0]   rsp_valid_o;
  logic [DW-1:0]   rsp_data_o;
  logic            flush_i = 1'b0;
  logic            busy_o;
  logic            err_o;
  logic            lifo_srst;
  logic            lifo_wr;
  logic [DW-1:0]   lifo_wdata;
  logic            lifo_rd;
  logic [DW-1:0]   lifo_q;
  logic [AW:0]     lifo_usedw;

  always #5 clk = ~clk;

  lifo_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i(clk), .arst_n_i(rst_n),
    .req_i(req_i), .req_pop_i(req_pop_i), .req_data_i(req_data_i),
    .ack_o(ack_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o),
    .lifo_srst_o(lifo_srst), .lifo_wrreq_o(lifo_wr), .lifo_data_o(lifo_wdata),
    .lifo_rdreq_o(lifo_rd), .lifo_q_i(lifo_q), .lifo_usedw_i(lifo_usedw)
  );

  // Behavioural LIFO: sync srst, registered q and usedw.
  logic [DW-1:0] lmem [DEPTH];
  logic [AW:0]   lsp;
  logic [AW:0]   lused;
  logic [AW:0]   usedw_off = '0;

  always @(posedge clk) begin
    if (lifo_srst) begin
      lsp   <= '0;
      lused <= '0;
      lq_reset();
    end else if (lifo_wr) begin
      lmem[lsp[AW-1:0]] <= lifo_wdata;
      lsp   <= lsp + 1'b1;
      lused <= lsp + 1'b1;
    end else if (lifo_rd) begin
      lifo_q <= lmem[AW'(lsp - 1'b1)];
      lsp    <= lsp - 1'b1;
      lused  <= lsp - 1'b1;
    end
  end

  task automatic lq_reset();
    lifo_q <= '0;
  endtask

  assign lifo_usedw = lused + usedw_off;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    int          due;
  } rsp_t;

  rsp_t          sb_q[$];
  logic [DW-1:0] ref_stack[$];
  int            ref_ptr = NR - 1;
  int            ref_cnt = 0;
  bit            ref_run = 0;
  bit            hold_all = 0;
  logic          exp_busy = 1'b1;
  logic          exp_srst = 1'b1;
  logic          exp_err = 1'b0;
  int            prev_g = -1;
  bit            prev_pop = 0;
  logic [DW-1:0] prev_data = '0;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  logic [NR-1:0] pend = '0;
  logic [NR-1:0] popv = '0;
  logic [DW-1:0] pdata [NR];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic req(input int k, input bit pop, input logic [DW-1:0] d);
    pend[k]  = 1'b1;
    popv[k]  = pop;
    pdata[k] = d;
  endtask

  // One clock: drive, check outputs of the current cycle, advance reference.
  task automatic step();
    int            g;
    int            k;
    logic [NR-1:0] exp_ack;
    logic [NR-1:0] exp_rv;
    rsp_t          r;
    req_i     = pend;
    req_pop_i = popv;
    for (int j = 0; j < NR; j++) req_data_i[j*DW +: DW] = pdata[j];
    #1;
    g = -1;
    if (ref_run) begin
      for (int i = 1; i <= NR; i++) begin
        k = (ref_ptr + i) % NR;
        if (g < 0 && pend[k] && (popv[k] ? (ref_cnt > 0) : (ref_cnt < DEPTH))) g = k;
      end
    end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check_eq("ack", ack_o, exp_ack);
    check_eq("busy", busy_o, exp_busy);
    check_eq("lifo_srst", lifo_srst, exp_srst);
    check_eq("err", err_o, exp_err);
    check_eq("lifo_wrreq", lifo_wr, prev_g >= 0 && !prev_pop);
    check_eq("lifo_rdreq", lifo_rd, prev_g >= 0 && prev_pop);
    if (prev_g >= 0 && !prev_pop) check_eq("lifo_data", lifo_wdata, prev_data);
    exp_rv = '0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      r = sb_q.pop_front();
      exp_rv[r.idx] = 1'b1;
      check_eq("rsp_data", rsp_data_o, r.data);
      $display("rsp  req%0d data=%02h (cycle %0d)", r.idx, r.data, cyc);
    end
    check_eq("rsp_valid", rsp_valid_o, exp_rv);
    @(posedge clk);
    prev_g = g;
    if (g >= 0) begin
      ref_ptr   = g;
      prev_pop  = popv[g];
      prev_data = pdata[g];
      if (popv[g]) begin
        ref_cnt--;
        sb_q.push_back('{idx: g, data: ref_stack.pop_back(), due: cyc + 3});
        $display("pop  req%0d granted (cycle %0d)", g, cyc);
      end else begin
        ref_cnt++;
        ref_stack.push_back(pdata[g]);
        $display("push req%0d data=%02h (cycle %0d)", g, pdata[g], cyc);
      end
      pend[g] = hold_all;
      if (hold_all) pdata[g] = DW'($urandom);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_idle(input int n);
    pend = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_done(input int bound);
    int n;
    n = 0;
    while (pend != '0 && n < bound) begin
      step();
      n++;
    end
    if (pend != '0) check_eq("grant_timeout", 32'(pend), 32'd0);
  endtask

  initial begin
    for (int j = 0; j < NR; j++) pdata[j] = '0;
    @(negedge clk);
    step();
    step();
    // Reset release: two cycles of LIFO reset, then requester 0 served.
    rst_n = 1'b1;
    req(0, 0, 8'h11);
    step();
    step();
    exp_busy = 1'b0;
    exp_srst = 1'b0;
    ref_run  = 1;
    step();
    req(0, 1, 8'h00);
    run_until_done(10);
    run_idle(4);

    // All requesters pushing: rotation and full-stop at DEPTH.
    hold_all = 1;
    for (int j = 0; j < NR; j++) req(j, 0, DW'($urandom));
    for (int i = 0; i < DEPTH + 4; i++) step();
    hold_all = 0;
    popv[2]  = 1'b1;
    step();
    run_idle(1);
    while (ref_cnt > 0 && cyc < 2000) begin
      req(3, 1, 8'h00);
      step();
    end
    run_idle(4);

    // LIFO ordering across requesters.
    req(1, 0, 8'hA5);
    run_until_done(10);
    req(3, 0, 8'h3C);
    run_until_done(10);
    req(0, 1, 8'h00);
    run_until_done(10);
    run_idle(4);
    req(2, 1, 8'h00);
    run_until_done(10);
    run_idle(4);

    // Empty LIFO, pointer at 3: pop from 0 skipped in favour of push from 1.
    req(3, 0, 8'h77);
    run_until_done(10);
    req(3, 1, 8'h00);
    run_until_done(10);
    run_idle(4);
    req(0, 1, 8'h00);
    req(1, 0, 8'h5A);
    step();
    step();
    run_idle(4);

    // Flush with two pops in flight.
    for (int i = 0; i < 8; i++) begin
      req(i % NR, 0, DW'(8'h10 + i));
      run_until_done(10);
    end
    req(0, 1, 8'h00);
    step();
    req(1, 1, 8'h00);
    step();
    flush_i = 1'b1;
    step();
    flush_i  = 1'b0;
    ref_run  = 0;
    exp_busy = 1'b1;
    req(0, 1, 8'h00);
    step();
    step();
    exp_srst = 1'b1;
    step();
    exp_srst = 1'b0;
    exp_busy = 1'b0;
    ref_run  = 1;
    ref_cnt  = 0;
    ref_stack.delete();
    step();
    step();
    req(1, 0, 8'h99);
    step();
    step();
    run_idle(4);

    // Consistency checker: usedw skewed by one.
    usedw_off = 1;
    step();
`ifdef LIFO_ARB_CHECK_EN
    exp_err = 1'b1;
`endif
    usedw_off = 0;
    step();
    step();

    // Asynchronous reset with a pop in flight drops the response.
    req(0, 0, 8'h42);
    run_until_done(10);
    req(0, 1, 8'h00);
    step();
    rst_n    = 1'b0;
    sb_q.delete();
    ref_run  = 0;
    exp_busy = 1'b1;
    exp_srst = 1'b1;
    exp_err  = 1'b0;
    prev_g   = -1;
    pend     = '0;
    step();
    step();
    rst_n   = 1'b1;
    ref_ptr = NR - 1;
    ref_cnt = 0;
    ref_stack.delete();
    step();
    step();
    exp_busy = 1'b0;
    exp_srst = 1'b0;
    ref_run  = 1;
    req(2, 0, 8'hE7);
    step();
    run_idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
